// File: rtl/i2c_poll_sequencer.sv
// Poll sequencer driving one I2C master core: read the switch slave, then mirror
// the captured byte to the LED and FND slaves, with NACK retry and completion timeout.
module i2c_poll_sequencer #(
  parameter int unsigned POLL_CYCLES    = 100000,
  parameter logic [6:0]  ADDR_LED       = 7'h55,
  parameter logic [6:0]  ADDR_FND       = 7'h56,
  parameter logic [6:0]  ADDR_SW        = 7'h57,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_wdata,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata,
  output logic [7:0] sw_value,
  output logic       busy,
  output logic       cycle_done,
  output logic [7:0] err_count,
  output logic [6:0] last_err_addr
);

  localparam int unsigned PW = $clog2(POLL_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [2:0]    retry_q;
  logic [PW-1:0] poll_q;
  logic [TW-1:0] tmo_q;
  logic          m_valid_q;
  logic [6:0]    m_addr_q;
  logic          m_rw_q;
  logic [7:0]    m_wdata_q;
  logic [7:0]    sw_value_q;
  logic          busy_q;
  logic          cycle_done_q;
  logic [7:0]    err_count_q;
  logic [7:0]    err_count_d;
  logic [6:0]    last_err_addr_q;
  logic          fail_s;

  // Failure decode for the outstanding command; m_done has priority over the timeout.
  always_comb begin
    err_count_d = err_count_q;
    fail_s      = 1'b0;
    if (err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
    if (state_q == S_WAIT) begin
      if (m_done) begin
        fail_s = m_nack && (retry_q >= RETRY_MAX);
      end else begin
        fail_s = (tmo_q == TMO_LAST);
      end
    end else begin
      fail_s = 1'b0;
    end
  end

  // Sequencer FSM with registered command and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      idx_q           <= 2'd0;
      retry_q         <= 3'd0;
      poll_q          <= '0;
      tmo_q           <= '0;
      m_valid_q       <= 1'b0;
      m_addr_q        <= 7'd0;
      m_rw_q          <= 1'b0;
      m_wdata_q       <= 8'd0;
      sw_value_q      <= 8'd0;
      busy_q          <= 1'b0;
      cycle_done_q    <= 1'b0;
      err_count_q     <= 8'd0;
      last_err_addr_q <= 7'd0;
    end else begin
      cycle_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start || (enable && (poll_q == POLL_LAST))) begin
            poll_q    <= '0;
            state_q   <= S_ISSUE;
            busy_q    <= 1'b1;
            idx_q     <= 2'd0;
            retry_q   <= 3'd0;
            m_valid_q <= 1'b1;
            m_addr_q  <= ADDR_SW;
            m_rw_q    <= 1'b1;
            m_wdata_q <= 8'd0;
          end else if (enable) begin
            poll_q <= poll_q + PW'(1);
          end
        end
        S_ISSUE: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fail_s) begin
            err_count_q     <= err_count_d;
            last_err_addr_q <= m_addr_q;
            // A failed switch read leaves nothing valid to mirror, so the cycle ends here.
            if (idx_q == 2'd0) begin
              state_q      <= S_FINISH;
              cycle_done_q <= 1'b1;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (m_done && !m_nack) begin
            if (idx_q == 2'd0) begin
              sw_value_q <= m_rdata;
            end
            state_q <= S_NEXT;
          end else if (m_done) begin
            retry_q   <= retry_q + 3'd1;
            m_valid_q <= 1'b1;
            state_q   <= S_ISSUE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_NEXT: begin
          retry_q <= 3'd0;
          case (idx_q)
            2'd0: begin
              idx_q     <= 2'd1;
              m_valid_q <= 1'b1;
              m_addr_q  <= ADDR_LED;
              m_rw_q    <= 1'b0;
              m_wdata_q <= sw_value_q;
              state_q   <= S_ISSUE;
            end
            2'd1: begin
              idx_q     <= 2'd2;
              m_valid_q <= 1'b1;
              m_addr_q  <= ADDR_FND;
              m_rw_q    <= 1'b0;
              m_wdata_q <= sw_value_q;
              state_q   <= S_ISSUE;
            end
            default: begin
              state_q      <= S_FINISH;
              cycle_done_q <= 1'b1;
            end
          endcase
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid       = m_valid_q;
  assign m_addr        = m_addr_q;
  assign m_rw          = m_rw_q;
  assign m_wdata       = m_wdata_q;
  assign sw_value      = sw_value_q;
  assign busy          = busy_q;
  assign cycle_done    = cycle_done_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;

endmodule
